trap_arbiter: RTL and testbench

TRAP_ARBITER -- requirements
Module: trap_arbiter

---
 rtl/trap_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_trap_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/trap_arbiter.sv
// Trap arbiter: picks one synchronous exception or external interrupt per
// detect-stage instruction, raises it toward the core, waits for an
// acknowledge, then issues a one-cycle pipeline flush.

package trap_arbiter_pkg;
    // bit3 marks a memory op; bit layout below encodes size and direction
    typedef enum logic [3:0] {
        MEM_NONE = 4'h0,
        MEM_LB   = 4'h8,
        MEM_LH   = 4'h9,
        MEM_LW   = 4'hA,
        MEM_LBU  = 4'hB,
        MEM_LHU  = 4'hC,
        MEM_SB   = 4'hD,
        MEM_SH   = 4'hE,
        MEM_SW   = 4'hF
    } memInstType_t;
endpackage

// One interrupt line: 2-flop synchronizer, rising-edge detect, pending bit.
module trap_irq_lane (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_i,
    input  logic clr_i,
    output logic pend_o
);
    logic sync1, sync2, prev;

    // Synchronize, remember last level, and set pending on a new edge
    // (an edge in the same cycle as a clear keeps the bit set).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            pend_o <= 1'b0;
        end else begin
            sync1  <= irq_i;
            sync2  <= sync1;
            prev   <= sync2;
            pend_o <= (pend_o & ~clr_i) | (sync2 & ~prev);
        end
    end
endmodule

module trap_arbiter
    import trap_arbiter_pkg::*;
#(
    parameter int          NUM_IRQ   = 4,
    parameter logic [31:0] PC_BASE   = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT  = 32'h0000_FFFC,
    parameter logic [31:0] MEM_BASE  = 32'h0001_0000,
    parameter logic [31:0] MEM_LIMIT = 32'h0001_FFFF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        dataAddress_i,
    input  memInstType_t       memInstType_i,
    input  logic               priv_i,
    input  logic [31:0]        privCause_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irqEnable_i,
    input  logic               mieGlobal_i,
    input  logic               trapAck_i,
    input  logic               mret_i,
    output logic               trapReq_o,
    output logic [31:0]        trapCause_o,
    output logic [31:0]        trapInfo_o,
    output logic               trapIsIrq_o,
    output logic               flush_o,
    output logic               inTrap_o,
    output logic [NUM_IRQ-1:0] pending_o
);
    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_oh_q, irq_oh, elig, clr_vec;
    logic [31:0]        exc_cause, exc_info, pc_off, addr_off;
    logic [4:0]         irq_idx;
    logic               exc, irq_ok, take, ack_take;
    logic               mem_op, is_store, is_half, is_word, misal;

    // Offset-from-base compares avoid constant-folded "x < 0" checks
    assign pc_off   = pc_i - PC_BASE;
    assign addr_off = dataAddress_i - MEM_BASE;
    assign mem_op   = memInstType_i[3];
    assign is_store = memInstType_i inside {MEM_SB, MEM_SH, MEM_SW};
    assign is_half  = memInstType_i inside {MEM_LH, MEM_LHU, MEM_SH};
    assign is_word  = memInstType_i inside {MEM_LW, MEM_SW};
    assign misal    = (is_half && dataAddress_i[0]) ||
                      (is_word && dataAddress_i[1:0] != 2'b00);

    // Synchronous cause selection in fixed priority order
    always_comb begin
        exc       = 1'b1;
        exc_cause = 32'd0;
        exc_info  = pc_i;
        if (pc_i[1:0] != 2'b00) begin
            exc_cause = 32'd0;
        end else if (pc_off > (PC_LIMIT - PC_BASE)) begin
            exc_cause = 32'd1;
        end else if (mem_op && addr_off > (MEM_LIMIT - MEM_BASE)) begin
            exc_cause = is_store ? 32'd7 : 32'd5;
            exc_info  = dataAddress_i;
        end else if (priv_i) begin
            exc_cause = privCause_i;
        end else if (misal) begin
            exc_cause = is_store ? 32'd6 : 32'd4;
            exc_info  = dataAddress_i;
        end else begin
            exc = 1'b0;
        end
    end

    // Lowest-index eligible interrupt wins
    always_comb begin
        irq_idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (elig[i]) irq_idx = 5'(i);
    end

    assign elig     = pending_o & irqEnable_i;
    assign irq_oh   = NUM_IRQ'(1) << irq_idx;
    assign irq_ok   = (|elig) && mieGlobal_i && !inTrap_o && valid_i && !exc;
    assign take     = (state_q == IDLE) && valid_i && (exc || irq_ok);
    assign ack_take = (state_q == REQ) && trapAck_i;
    assign clr_vec  = ack_take ? irq_oh_q : '0;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_lane
        trap_irq_lane u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .irq_i  (irq_i[g]),
            .clr_i  (clr_vec[g]),
            .pend_o (pending_o[g])
        );
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: detect -> request -> one-cycle flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take)      state_d = REQ;
            REQ:     if (trapAck_i) state_d = FLUSH;
            FLUSH:                  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Capture the chosen trap; held unchanged until the next accepted trap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trapCause_o <= 32'd0;
            trapInfo_o  <= 32'd0;
            trapIsIrq_o <= 1'b0;
            irq_oh_q    <= '0;
        end else if (take) begin
            trapCause_o <= exc ? exc_cause : {1'b1, 31'(irq_idx) + 31'd16};
            trapInfo_o  <= exc ? exc_info : pc_i;
            trapIsIrq_o <= !exc;
            irq_oh_q    <= exc ? '0 : irq_oh;
        end
    end

    // In-trap flag: acknowledge sets, mret clears, set has priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       inTrap_o <= 1'b0;
        else if (ack_take) inTrap_o <= 1'b1;
        else if (mret_i)   inTrap_o <= 1'b0;
    end

    assign trapReq_o = (state_q == REQ);
    assign flush_o   = (state_q == FLUSH);
endmodule

// File: tb/tb_trap_arbiter.sv
// Directed bench for trap_arbiter with hand-computed expectations.
module tb_trap_arbiter;
    import trap_arbiter_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         valid_i;
    logic [31:0]  pc_i, dataAddress_i, privCause_i;
    memInstType_t memInstType_i;
    logic         priv_i;
    logic [3:0]   irq_i, irqEnable_i;
    logic         mieGlobal_i, trapAck_i, mret_i;
    logic         trapReq_o, trapIsIrq_o, flush_o, inTrap_o;
    logic [31:0]  trapCause_o, trapInfo_o;
    logic [3:0]   pending_o;

    int n_cmp = 0;
    int n_err = 0;

    trap_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .pc_i(pc_i),
        .dataAddress_i(dataAddress_i), .memInstType_i(memInstType_i),
        .priv_i(priv_i), .privCause_i(privCause_i), .irq_i(irq_i),
        .irqEnable_i(irqEnable_i), .mieGlobal_i(mieGlobal_i),
        .trapAck_i(trapAck_i), .mret_i(mret_i), .trapReq_o(trapReq_o),
        .trapCause_o(trapCause_o), .trapInfo_o(trapInfo_o),
        .trapIsIrq_o(trapIsIrq_o), .flush_o(flush_o), .inTrap_o(inTrap_o),
        .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 ns after the rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Raise a request with the given detect-stage inputs and check it
    task automatic raise(input string tag, input logic [31:0] pc, input memInstType_t mt,
                         input logic [31:0] addr, input logic [31:0] cause,
                         input logic [31:0] info, input logic is_irq);
        valid_i = 1'b1; pc_i = pc; memInstType_i = mt; dataAddress_i = addr;
        step();
        chk({tag, "_req"},   trapReq_o,   1'b1);
        chk({tag, "_cause"}, trapCause_o, cause);
        chk({tag, "_info"},  trapInfo_o,  info);
        chk({tag, "_irq"},   trapIsIrq_o, is_irq);
        valid_i = 1'b0; memInstType_i = MEM_NONE;
    endtask

    // Acknowledge, pass through FLUSH, then optionally return from trap
    task automatic ack_ret(input string tag, input logic do_mret);
        trapAck_i = 1'b1;
        step();
        chk({tag, "_flush"},  flush_o,  1'b1);
        chk({tag, "_intrap"}, inTrap_o, 1'b1);
        trapAck_i = 1'b0;
        step();
        chk({tag, "_flush_end"}, flush_o, 1'b0);
        if (do_mret) begin
            mret_i = 1'b1;
            step();
            mret_i = 1'b0;
            chk({tag, "_mret"}, inTrap_o, 1'b0);
        end
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; pc_i = 32'h40; dataAddress_i = 32'h1_0000;
        memInstType_i = MEM_NONE; priv_i = 1'b0; privCause_i = 32'd2;
        irq_i = 4'b0; irqEnable_i = 4'b0; mieGlobal_i = 1'b0;
        trapAck_i = 1'b0; mret_i = 1'b0;

        // Reset state
        step(); step();
        chk("rst_req", trapReq_o, 1'b0);
        chk("rst_flush", flush_o, 1'b0);
        chk("rst_intrap", inTrap_o, 1'b0);
        chk("rst_pend", pending_o, 4'b0);
        chk("rst_cause", trapCause_o, 32'd0);
        rst_ni = 1'b1;
        step();
        chk("idle_req", trapReq_o, 1'b0);

        // Misaligned PC, held through unrelated detect inputs
        raise("pcmis", 32'h102, MEM_NONE, 32'h1_0000, 32'd0, 32'h102, 1'b0);
        valid_i = 1'b1; pc_i = 32'h41;
        step(); step(); step();
        chk("hold_req", trapReq_o, 1'b1);
        chk("hold_cause", trapCause_o, 32'd0);
        chk("hold_info", trapInfo_o, 32'h102);
        valid_i = 1'b0; pc_i = 32'h40;
        mret_i = 1'b1;                       // ack wins over simultaneous mret
        ack_ret("pcmis", 1'b0);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        chk("pcmis_mret", inTrap_o, 1'b0);

        // Data-side exceptions
        raise("sw_oor", 32'h40, MEM_SW, 32'h2_0000, 32'd7, 32'h2_0000, 1'b0);
        ack_ret("sw_oor", 1'b1);
        raise("lw_oor", 32'h40, MEM_LW, 32'h0, 32'd5, 32'h0, 1'b0);
        ack_ret("lw_oor", 1'b1);
        raise("lh_mis", 32'h40, MEM_LH, 32'h1_0003, 32'd4, 32'h1_0003, 1'b0);
        ack_ret("lh_mis", 1'b1);
        raise("sh_mis", 32'h40, MEM_SH, 32'h1_0001, 32'd6, 32'h1_0001, 1'b0);
        ack_ret("sh_mis", 1'b1);
        priv_i = 1'b1; privCause_i = 32'd11;
        raise("priv", 32'h80, MEM_NONE, 32'h1_0000, 32'd11, 32'h80, 1'b0);
        priv_i = 1'b0;
        ack_ret("priv", 1'b1);
        valid_i = 1'b1; memInstType_i = MEM_LB; dataAddress_i = 32'h1_0003;
        step();
        chk("lb_notrap", trapReq_o, 1'b0);
        valid_i = 1'b0; memInstType_i = MEM_NONE;

        // Interrupt latency: edge k is the first edge seeing irq high
        mieGlobal_i = 1'b1; irqEnable_i = 4'b0100; valid_i = 1'b1; pc_i = 32'h40;
        irq_i = 4'b0100;
        step();                              // edge k
        chk("irq_k0", pending_o, 4'b0000);
        step();                              // edge k+1
        chk("irq_k1", pending_o, 4'b0000);
        step();                              // edge k+2
        chk("irq_k2_pend", pending_o, 4'b0100);
        chk("irq_k2_req", trapReq_o, 1'b0);
        raise("irq2", 32'h40, MEM_NONE, 32'h1_0000, 32'h8000_0012, 32'h40, 1'b1);
        ack_ret("irq2", 1'b1);
        chk("irq2_clr", pending_o, 4'b0000);
        irq_i = 4'b0000;

        // Exception beats pending interrupts; masked while in trap
        irqEnable_i = 4'b1010; irq_i = 4'b1010;
        step(); step(); step(); step();
        chk("two_pend", pending_o, 4'b1010);
        raise("exc_first", 32'h42, MEM_NONE, 32'h1_0000, 32'd0, 32'h42, 1'b0);
        ack_ret("exc_first", 1'b0);
        chk("exc_keep_pend", pending_o, 4'b1010);
        valid_i = 1'b1; pc_i = 32'h40;
        step();
        chk("masked_req", trapReq_o, 1'b0);
        raise("pcoor", 32'h2_0000, MEM_NONE, 32'h1_0000, 32'd1, 32'h2_0000, 1'b0);
        ack_ret("pcoor", 1'b1);
        raise("irq1", 32'h40, MEM_NONE, 32'h1_0000, 32'h8000_0011, 32'h40, 1'b1);
        ack_ret("irq1", 1'b1);
        chk("irq3_left", pending_o, 4'b1000);

        // Reset mid-REQ aborts at once
        raise("irq3", 32'h44, MEM_NONE, 32'h1_0000, 32'h8000_0013, 32'h44, 1'b1);
        irq_i = 4'b0000;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_req", trapReq_o, 1'b0);
        chk("arst_pend", pending_o, 4'b0000);
        chk("arst_intrap", inTrap_o, 1'b0);
        chk("arst_cause", trapCause_o, 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        chk("post_rst_req", trapReq_o, 1'b0);
        trapAck_i = 1'b1;                    // ignored outside REQ
        step();
        trapAck_i = 1'b0;
        chk("stray_ack_flush", flush_o, 1'b0);
        chk("stray_ack_intrap", inTrap_o, 1'b0);
        raise("post_rst", 32'h103, MEM_NONE, 32'h1_0000, 32'd0, 32'h103, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
